pcpi_resp_arb: RTL and testbench
================================

Name: pcpi_resp_arb

Overview:
Parametrised PCPI response arbiter for NCH co-processor channels (MUL, DIV, external PCPI, ...) in front of the core's pcpi_int_* interface.
- Replaces a fixed 2-way combinational response mux with a registered, FSM-sequenced merge.
- Adds per-channel compile-time enable, fixed lowest-index priority, a no-wait timeout, and a one-response-per-instruction guarantee.
- Sits between the core's PCPI request (pcpi_valid) and the co-processor cores.

Parameters:
NCH, 3, number of co-processor channels (1..8)
XLEN, 32, result width
CH_EN, {NCH{1'b1}}, per-channel enable mask; a disabled channel's inputs are ignored everywhere
TIMEOUT, 16, cycles in BUSY with no enabled wait/ready before timeout (>=2)
SELW, $clog2(NCH) (min 1), width of the select index

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
pcpi_valid  in  1  core request for the current instruction
ch_wr  in  NCH  per-channel write-back request
ch_rd  in  NCH*XLEN  per-channel result; channel i is at [i*XLEN +: XLEN]
ch_wait  in  NCH  per-channel busy
ch_ready  in  NCH  per-channel one-cycle completion pulse
pcpi_int_wr  out  1  registered write-back flag
pcpi_int_rd  out  XLEN  registered result
pcpi_int_wait  out  1  registered OR of enabled ch_wait while in BUSY
pcpi_int_ready  out  1  one-cycle completion pulse
pcpi_int_timeout  out  1  one-cycle pulse: no channel claimed the instruction
pcpi_int_sel  out  SELW  index of the responding channel; held until the next response
pcpi_int_collision  out  1  see Optional Feature

Behaviour:
- Reset (async, resetn=0): state=IDLE, counter=0, all outputs 0 (pcpi_int_rd=0, not X).
- Masking: en_ready = ch_ready & CH_EN and en_wait = ch_wait & CH_EN. All other logic uses only the masked vectors.
- FSM states: IDLE, BUSY, RESP, TOUT, DONE.
- IDLE: on pcpi_valid=1, go to BUSY and clear the counter.
- BUSY transitions, evaluated in this order:
  - pcpi_valid=0: abort to IDLE; no pulse is issued.
  - |en_ready: select the lowest set index k and capture ch_wr[k], ch_rd[k] and k into the output registers; go to RESP.
  - |en_wait: clear the counter; stay in BUSY.
  - Otherwise: counter+1. When counter==TIMEOUT-1, go to TOUT.
- RESP: pcpi_int_ready=1 for exactly this cycle, with wr/rd/sel valid; go to DONE.
- TOUT: pcpi_int_timeout=1 for exactly this cycle; pcpi_int_wr=0; go to DONE.
- DONE: ignore all channel inputs; go to IDLE when pcpi_valid=0. This guarantees one response or timeout per instruction.
- Latency: ch_ready sampled in cycle T gives pcpi_int_ready in T+1.
- pcpi_int_wait is registered: it reflects en_wait from the previous cycle, and only while in BUSY; otherwise it is 0. The core's timeout is therefore disabled by wait one cycle late; TIMEOUT>=2 tolerates this.
- Outputs outside their state:
  - pcpi_int_wr is 0 outside RESP.
  - pcpi_int_rd and pcpi_int_sel hold their last value.
- Simultaneous ready and wait in BUSY: ready wins.
- ready arriving in IDLE or DONE is dropped silently.
- Counter width: $clog2(TIMEOUT)+1. It saturates and never wraps.
- resetn asserted mid-BUSY or mid-RESP: return to IDLE immediately; no pulse after release.

Optional Feature:
PCPI_ARB_COLLISION_EN
- Defined: when the winning capture sees more than one bit set in en_ready, pcpi_int_collision pulses in the RESP cycle. A saturating 8-bit internal collision counter also increments; it is visible only to the bench.
- Undefined: pcpi_int_collision is tied 0, no counter exists, and priority resolution is unchanged.

Decomposition:
- Package pcpi_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP, TOUT, DONE);
  - the default TIMEOUT constant;
  - a function lowest_set(vec) returning the index and a found flag.
- Sub-module pcpi_prio_enc (NCH in, SELW index + valid out) is purely combinational and reused for future request-side arbitration.

Test Plan:
1. NCH=3. valid=1; ch_wait[1]=1 for 5 cycles, then ch_ready[1]=1, ch_wr[1]=1, ch_rd[1]=32'h1234_5678 -> pcpi_int_wait=1 from cycle 2 to 6; next cycle ready=1, rd=32'h1234_5678, wr=1, sel=1; exactly one pulse.
2. Same-cycle ch_ready=3'b110, rd[1]=32'hA, rd[2]=32'hB -> rd=32'hA, sel=1; with PCPI_ARB_COLLISION_EN, collision=1 in the same cycle, else 0.
3. valid=1, no wait/ready, TIMEOUT=16 -> pcpi_int_timeout pulses once, 17 cycles after valid rises; ready stays 0; ready after that is ignored until valid drops.
4. CH_EN=3'b101. ch_ready[1]=1, ch_rd[1]=32'hDEAD -> no ready pulse, output ignored; ch_ready[0]=1 next -> response with sel=0.
5. valid held high after a response, second ch_ready[2] pulse in DONE -> no second pulse; valid low then high -> new BUSY, accepts ch_ready[2].
6. resetn low for 1 cycle during BUSY with ch_ready pending -> all outputs 0; after release with valid=0, state stays IDLE and no pulse appears.

Source files
------------

// File: rtl/pcpi_arb_pkg.sv
// Shared types and helpers for the PCPI response arbiter.
// Optional build macro used by the arbiter: PCPI_ARB_COLLISION_EN.
package pcpi_arb_pkg;

  localparam int unsigned DEF_TIMEOUT = 16;
  localparam int unsigned MAX_CH      = 8;
  localparam int unsigned MAX_SELW    = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BUSY = 3'd1,
    RESP = 3'd2,
    TOUT = 3'd3,
    DONE = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic                found;
    logic [MAX_SELW-1:0] idx;
  } lowest_t;

  // Index of the lowest set bit; scanning downward lets the lowest index win.
  function automatic lowest_t lowest_set(input logic [MAX_CH-1:0] vec);
    lowest_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.found = 1'b1;
        r.idx   = MAX_SELW'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pcpi_prio_enc.sv
// Combinational fixed-priority encoder: lowest set request index wins.
module pcpi_prio_enc
  import pcpi_arb_pkg::*;
#(
  parameter int unsigned NCH  = 3,
  parameter int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]  req_i,
  output logic [SELW-1:0] idx_c_o,
  output logic            valid_c_o
);

  logic [MAX_CH-1:0] req_pad;
  lowest_t           res;

  always_comb begin
    req_pad   = MAX_CH'(req_i);
    res       = lowest_set(req_pad);
    idx_c_o   = SELW'(res.idx);
    valid_c_o = res.found;
  end

endmodule

// File: rtl/pcpi_resp_arb.sv
// Registered, FSM-sequenced merge of NCH co-processor responses onto pcpi_int_*.
// Optional build macro: PCPI_ARB_COLLISION_EN (collision pulse + saturating counter).
module pcpi_resp_arb
  import pcpi_arb_pkg::*;
#(
  parameter int unsigned    NCH     = 3,
  parameter int unsigned    XLEN    = 32,
  parameter logic [NCH-1:0] CH_EN   = {NCH{1'b1}},
  parameter int unsigned    TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned    SELW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pcpi_valid,
  input  logic [NCH-1:0]      ch_wr,
  input  logic [NCH*XLEN-1:0] ch_rd,
  input  logic [NCH-1:0]      ch_wait,
  input  logic [NCH-1:0]      ch_ready,
  output logic                pcpi_int_wr,
  output logic [XLEN-1:0]     pcpi_int_rd,
  output logic                pcpi_int_wait,
  output logic                pcpi_int_ready,
  output logic                pcpi_int_timeout,
  output logic [SELW-1:0]     pcpi_int_sel,
  output logic                pcpi_int_collision
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              ready_q, ready_d;
  logic              tout_q, tout_d;
  logic              wait_q, wait_d;

  logic [NCH-1:0]    en_ready, en_wait;
  logic [SELW-1:0]   win_idx;
  logic              win_valid;
  logic [XLEN-1:0]   win_rd;

  assign en_ready = ch_ready & CH_EN;
  assign en_wait  = ch_wait & CH_EN;

  pcpi_prio_enc #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_prio (
    .req_i     (en_ready),
    .idx_c_o   (win_idx),
    .valid_c_o (win_valid)
  );

  assign win_rd = ch_rd[int'(win_idx) * XLEN +: XLEN];

  // Next-state and registered-output values; ready beats wait beats timeout in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    rd_d    = rd_q;
    sel_d   = sel_q;
    ready_d = 1'b0;
    tout_d  = 1'b0;
    wait_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pcpi_valid) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!pcpi_valid) begin
          state_d = IDLE;
        end else if (win_valid) begin
          state_d = RESP;
          wr_d    = ch_wr[win_idx];
          rd_d    = win_rd;
          sel_d   = win_idx;
          ready_d = 1'b1;
        end else if (|en_wait) begin
          cnt_d  = '0;
          wait_d = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = TOUT;
          tout_d  = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = DONE;
      TOUT:    state_d = DONE;
      DONE: begin
        if (!pcpi_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      sel_q   <= '0;
      ready_q <= 1'b0;
      tout_q  <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      sel_q   <= sel_d;
      ready_q <= ready_d;
      tout_q  <= tout_d;
      wait_q  <= wait_d;
    end
  end

  assign pcpi_int_wr      = wr_q;
  assign pcpi_int_rd      = rd_q;
  assign pcpi_int_wait    = wait_q;
  assign pcpi_int_ready   = ready_q;
  assign pcpi_int_timeout = tout_q;
  assign pcpi_int_sel     = sel_q;

`ifdef PCPI_ARB_COLLISION_EN
  logic       coll_d, coll_q;
  logic [7:0] coll_cnt_q;

  // More than one enabled ready at the winning capture.
  assign coll_d = (state_q == BUSY) && pcpi_valid && win_valid &&
                  (|(en_ready & (en_ready - NCH'(1))));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= 8'd0;
    end else begin
      coll_q <= coll_d;
      if (coll_d && (coll_cnt_q != 8'hFF)) coll_cnt_q <= coll_cnt_q + 8'd1;
    end
  end

  assign pcpi_int_collision = coll_q;
`else
  assign pcpi_int_collision = 1'b0;
`endif

endmodule

// File: tb/tb_pcpi_resp_arb.sv
// Scoreboard bench for pcpi_resp_arb: full-enable instance plus a CH_EN=3'b101 instance.
module tb_pcpi_resp_arb;

  localparam int unsigned NCH  = 3;
  localparam int unsigned XLEN = 32;
  localparam int unsigned SELW = 2;

`ifdef PCPI_ARB_COLLISION_EN
  localparam logic EXP_COLL = 1'b1;
`else
  localparam logic EXP_COLL = 1'b0;
`endif

  typedef struct {
    bit              is_tout;
    logic            wr;
    logic [XLEN-1:0] rd;
    logic [SELW-1:0] sel;
    logic            coll;
  } exp_t;

  logic                clk = 1'b0;
  logic                resetn;
  logic                pcpi_valid;
  logic [NCH-1:0]      ch_wr, ch_wait, ch_ready;
  logic [NCH*XLEN-1:0] ch_rd;

  logic            a_wr, a_wait, a_ready, a_tout, a_coll;
  logic [XLEN-1:0] a_rd;
  logic [SELW-1:0] a_sel;
  logic            m_wr, m_wait, m_ready, m_tout, m_coll;
  logic [XLEN-1:0] m_rd;
  logic [SELW-1:0] m_sel;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t qa[$];
  exp_t qm[$];
  bit   mon_m_en = 1'b0;

  always #5 clk = ~clk;

  pcpi_resp_arb #(.NCH(NCH), .XLEN(XLEN), .CH_EN(3'b111), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid),
    .ch_wr(ch_wr), .ch_rd(ch_rd), .ch_wait(ch_wait), .ch_ready(ch_ready),
    .pcpi_int_wr(a_wr), .pcpi_int_rd(a_rd), .pcpi_int_wait(a_wait),
    .pcpi_int_ready(a_ready), .pcpi_int_timeout(a_tout),
    .pcpi_int_sel(a_sel), .pcpi_int_collision(a_coll)
  );

  pcpi_resp_arb #(.NCH(NCH), .XLEN(XLEN), .CH_EN(3'b101), .TIMEOUT(16)) dut_m (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid),
    .ch_wr(ch_wr), .ch_rd(ch_rd), .ch_wait(ch_wait), .ch_ready(ch_ready),
    .pcpi_int_wr(m_wr), .pcpi_int_rd(m_rd), .pcpi_int_wait(m_wait),
    .pcpi_int_ready(m_ready), .pcpi_int_timeout(m_tout),
    .pcpi_int_sel(m_sel), .pcpi_int_collision(m_coll)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int ch, input logic [XLEN-1:0] v);
    ch_rd[ch*XLEN +: XLEN] = v;
  endtask

  function automatic exp_t mk(input bit t, input logic w, input logic [XLEN-1:0] r,
                              input logic [SELW-1:0] s, input logic c);
    exp_t e;
    e.is_tout = t; e.wr = w; e.rd = r; e.sel = s; e.coll = c;
    return e;
  endfunction

  task automatic compare(input string p, input exp_t e, input logic rdy, input logic to,
                         input logic w, input logic [XLEN-1:0] r, input logic [SELW-1:0] s,
                         input logic c);
    check({p, "_kind"}, {62'd0, rdy, to}, e.is_tout ? 64'd1 : 64'd2);
    check({p, "_wr"}, 64'(w), 64'(e.is_tout ? 1'b0 : e.wr));
    if (!e.is_tout) begin
      check({p, "_rd"}, 64'(r), 64'(e.rd));
      check({p, "_sel"}, 64'(s), 64'(e.sel));
      check({p, "_coll"}, 64'(c), 64'(e.coll));
    end
  endtask

  // Monitors: pop an expectation on every ready/timeout pulse; otherwise wr and collision stay 0.
  always @(negedge clk) begin
    if (resetn) begin
      if (a_ready || a_tout) begin
        if (qa.size() == 0) check("a_unexpected_pulse", {a_ready, a_tout}, 64'd0);
        else compare("a", qa.pop_front(), a_ready, a_tout, a_wr, a_rd, a_sel, a_coll);
      end else begin
        check("a_idle_wr_coll", {a_wr, a_coll}, 64'd0);
      end
      if (mon_m_en && (m_ready || m_tout)) begin
        if (qm.size() == 0) check("m_unexpected_pulse", {m_ready, m_tout}, 64'd0);
        else compare("m", qm.pop_front(), m_ready, m_tout, m_wr, m_rd, m_sel, m_coll);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    resetn = 1'b0; pcpi_valid = 1'b0;
    ch_wr = '0; ch_rd = '0; ch_wait = '0; ch_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {a_wr, a_wait, a_ready, a_tout, a_coll}, 64'd0);
    check("rst_rd", 64'(a_rd), 64'd0);
    check("rst_sel", 64'(a_sel), 64'd0);
    step();
    resetn = 1'b1;
    step();

    // 1: wait on channel 1 for five cycles, then a response
    pcpi_valid = 1'b1;
    step();
    ch_wait = 3'b010;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("t1_wait", 64'(a_wait), 64'(c >= 2));
      step();
    end
    ch_wait = '0; ch_ready = 3'b010; ch_wr = 3'b010; set_rd(1, 32'h1234_5678);
    qa.push_back(mk(0, 1'b1, 32'h1234_5678, 2'd1, 1'b0));
    @(negedge clk);
    check("t1_wait_c6", 64'(a_wait), 64'd1);
    step();
    ch_ready = '0; ch_wr = '0;
    @(negedge clk);
    check("t1_wait_resp", 64'(a_wait), 64'd0);
    step();
    pcpi_valid = 1'b0;
    step(); step();

    // 2: simultaneous ready on channels 1 and 2
    pcpi_valid = 1'b1;
    step();
    ch_ready = 3'b110; ch_wr = 3'b110; set_rd(1, 32'hA); set_rd(2, 32'hB);
    qa.push_back(mk(0, 1'b1, 32'hA, 2'd1, EXP_COLL));
    step();
    ch_ready = '0; ch_wr = '0;
    step();
    pcpi_valid = 1'b0;
    step(); step();

    // 3: nobody claims the instruction
    pcpi_valid = 1'b1;
    qa.push_back(mk(1, 1'b0, '0, '0, 1'b0));
    seen = 1'b0; lat = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (a_tout) begin seen = 1'b1; lat = n; end
      else step();
    end
    check("t3_tout_seen", 64'(seen), 64'd1);
    check("t3_tout_latency", 64'(lat), 64'd17);
    step();
    @(negedge clk);
    check("t3_tout_one_cycle", 64'(a_tout), 64'd0);
    ch_ready = 3'b001; ch_wr = 3'b001;
    step();
    ch_ready = '0; ch_wr = '0;
    step();
    pcpi_valid = 1'b0;
    step(); step();

    // 4: channel 1 disabled on dut_m
    mon_m_en = 1'b1;
    pcpi_valid = 1'b1;
    step();
    ch_ready = 3'b010; ch_wr = 3'b010; set_rd(1, 32'hDEAD);
    qa.push_back(mk(0, 1'b1, 32'hDEAD, 2'd1, 1'b0));
    step();
    ch_ready = 3'b001; ch_wr = 3'b001; set_rd(0, 32'hBEEF);
    qm.push_back(mk(0, 1'b1, 32'hBEEF, 2'd0, 1'b0));
    @(negedge clk);
    check("t4_m_masked_no_ready", 64'(m_ready), 64'd0);
    step();
    ch_ready = '0; ch_wr = '0;
    step();
    pcpi_valid = 1'b0;
    step(); step();
    mon_m_en = 1'b0;

    // 5: second ready in DONE is dropped; new instruction is accepted
    pcpi_valid = 1'b1;
    step();
    ch_ready = 3'b100; ch_wr = 3'b100; set_rd(2, 32'h00C0_FFEE);
    qa.push_back(mk(0, 1'b1, 32'h00C0_FFEE, 2'd2, 1'b0));
    step();
    ch_ready = '0; ch_wr = '0;
    step();
    ch_ready = 3'b100; ch_wr = 3'b100; set_rd(2, 32'h0BAD);
    @(negedge clk);
    check("t5_sel_hold", 64'(a_sel), 64'd2);
    check("t5_rd_hold", 64'(a_rd), 64'h00C0_FFEE);
    step();
    ch_ready = '0; ch_wr = '0;
    step(); step();
    pcpi_valid = 1'b0;
    step();
    pcpi_valid = 1'b1;
    step();
    ch_ready = 3'b100; ch_wr = 3'b000; set_rd(2, 32'h55AA);
    qa.push_back(mk(0, 1'b0, 32'h55AA, 2'd2, 1'b0));
    step();
    ch_ready = '0;
    step();
    pcpi_valid = 1'b0;
    step(); step();

    // 6: reset during BUSY with a ready pending
    pcpi_valid = 1'b1;
    step();
    ch_ready = 3'b001; ch_wr = 3'b001; set_rd(0, 32'h77);
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_outs", {a_wr, a_wait, a_ready, a_tout, a_coll}, 64'd0);
    check("t6_rst_rd", 64'(a_rd), 64'd0);
    check("t6_rst_sel", 64'(a_sel), 64'd0);
    pcpi_valid = 1'b0;
    step();
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_no_pulse", {a_ready, a_tout}, 64'd0);
      step();
    end
    ch_ready = '0; ch_wr = '0;
    step(); step();

    check("sb_a_empty", 64'(qa.size()), 64'd0);
    check("sb_m_empty", 64'(qm.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
